lsu_mem_ctrl: RTL

Load/store unit sitting between the main control decoder and the data-memory bus.
- Consumes the decoder's mem_read/mem_write strobes, func3 and the ALU-computed address.
- Issues a single-outstanding req/ack bus transaction with byte enables.
- Stalls the pipeline while the access is pending, then returns sign- or zero-extended load data aligned for write-back.

---
 rtl/lsu_mem_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns decoder mem strobes into a single-outstanding req/ack
// bus access with byte enables, stalls while pending, returns extended load data.
module lsu_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            func3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  misalign,
  output logic                  bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  req_d, we_d, lv_d, mis_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, ld_d;
  logic [3:0]            be_d;
  logic                  stall_c;

  logic                  op, aligned;
  logic [3:0]            be_req;
  logic [DATA_WIDTH-1:0] wdata_req, ext;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  sgn;

  // Request decode: size from func3[1:0] (00 byte, 01 half, else word)
  always_comb begin
    op        = mem_read | mem_write;
    aligned   = 1'b1;
    be_req    = 4'b1111;
    wdata_req = store_data;
    case (func3[1:0])
      2'b00: begin
        be_req    = 4'b0001 << addr[1:0];
        wdata_req = {4{store_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr[0];
        be_req    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_req = {2{store_data[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
    if (mem_read) be_req = 4'b1111;
  end

  // Lane select and sign/zero extension of the returning read word
  always_comb begin
    sgn = ~f3_q[2];
    case (off_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ext = {{(DATA_WIDTH-8){sgn & lane_b[7]}}, lane_b};
      2'b01:   ext = {{(DATA_WIDTH-16){sgn & lane_h[15]}}, lane_h};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    req_d   = bus_req;
    we_d    = bus_we;
    addr_d  = bus_addr;
    be_d    = bus_be;
    wdata_d = bus_wdata;
    ld_d    = load_data;
    lv_d    = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = op & aligned;
        if (op && aligned) begin
          state_d = BUSY;
          cnt_d   = '0;
          f3_d    = func3;
          off_d   = addr[1:0];
          req_d   = 1'b1;
          we_d    = ~mem_read;
          addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          be_d    = be_req;
          wdata_d = wdata_req;
        end else if (op) begin
          mis_d = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (!bus_we) begin
            ld_d = ext;
            lv_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall must fall as soon as reset asserts, even with requests still driven
  assign stall = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      bus_req    <= req_d;
      bus_we     <= we_d;
      bus_addr   <= addr_d;
      bus_be     <= be_d;
      bus_wdata  <= wdata_d;
      load_data  <= ld_d;
      load_valid <= lv_d;
      misalign   <= mis_d;
      bus_err    <= err_d;
    end
  end

endmodule
